// File: rtl/cpu_io_bridge_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
//
// Shared definitions for the host/CPU I/O bridge.
//   DW_DEFAULT    : default data word width (matches the CPU din/dout port)
//   DEPTH_DEFAULT : default number of entries in each bridge FIFO
//   word_t        : one data word at the default width
// -----------------------------------------------------------------------------
package cpu_io_pkg;

    localparam int DW_DEFAULT    = 16;
    localparam int DEPTH_DEFAULT = 8;

    typedef logic [DW_DEFAULT-1:0] word_t;

endpackage : cpu_io_pkg

// File: rtl/cpu_io_bridge_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-word-fall-through FIFO used for both directions of the
// bridge.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   srst     : synchronous active-high reset; clears pointers and count
//              (storage contents are left alone)
//   wr_en    : push wr_data this cycle (ignored when full with no pop)
//   wr_data  : word to push
//   rd_en    : pop the head word this cycle (ignored when empty)
//   rd_data  : current head word, forced to 0 while the FIFO is empty
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = CW - 1;

    // Storage. The head is read asynchronously so a word pushed at one edge
    // is visible on rd_data in the very next cycle (fall-through).
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full_w;
    logic empty_w;
    logic do_push;
    logic do_pop;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Qualify requests locally so the pointers can never run past each other
    // even if a caller forgets to gate. A pop frees the slot the push uses
    // when full, because the head being popped is read before it is written.
    assign do_pop  = rd_en && !empty_w;
    assign do_push = wr_en && (!full_w || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write has no reset: stale words are unreachable once the
    // pointers are cleared, so there is no need to scrub them.
    always_ff @(posedge clk) begin
        if (do_push && !srst) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = empty_w ? '0 : mem[rd_ptr_q];
    assign full    = full_w;
    assign empty   = empty_w;
    assign count   = count_q;

endmodule : sync_fifo

// File: rtl/cpu_io_bridge.sv
// -----------------------------------------------------------------------------
// cpu_io_bridge
//
// Host-side I/O bridge for the 16-bit CPU's din/dout port. Host words are
// buffered in an input FIFO and presented on cpu_din; CPU writes on cpu_dout
// are captured in an output FIFO that the host drains with valid/ready.
//
// Ports:
//   clk, sys_rst        : clock and synchronous active-high reset
//   host_in_data/valid  : host -> CPU word and its valid
//   host_in_ready       : input FIFO has room (registered state only)
//   cpu_din/valid       : head of input FIFO, 0 when empty / non-empty flag
//   cpu_din_rd          : CPU consumed cpu_din
//   cpu_dout/_we        : CPU output word and its write strobe
//   host_out_data/valid : head of output FIFO, 0 when empty / non-empty flag
//   host_out_ready      : host accepts host_out_data
//   in_count/out_count  : FIFO occupancies
//   in_underflow        : sticky, cpu_din_rd seen while input FIFO empty
//   out_overflow        : sticky, CPU write dropped because output FIFO full
// -----------------------------------------------------------------------------
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     sys_rst,

    input  logic [DW-1:0]            host_in_data,
    input  logic                     host_in_valid,
    output logic                     host_in_ready,

    output logic [DW-1:0]            cpu_din,
    output logic                     cpu_din_valid,
    input  logic                     cpu_din_rd,

    input  logic [DW-1:0]            cpu_dout,
    input  logic                     cpu_dout_we,

    output logic [DW-1:0]            host_out_data,
    output logic                     host_out_valid,
    input  logic                     host_out_ready,

    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     in_underflow,
    output logic                     out_overflow
);

    // ---------------------------------------------------------------------
    // Input path: host -> CPU
    // ---------------------------------------------------------------------
    logic in_full;
    logic in_empty;
    logic in_push;
    logic in_pop;

    // Ready depends only on the registered occupancy. When full, a pop in
    // the same cycle does not open the door; ready rises the cycle after.
    assign host_in_ready = !in_full;
    assign in_push       = host_in_valid && !in_full;
    assign in_pop        = cpu_din_rd && !in_empty;
    assign cpu_din_valid = !in_empty;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .srst    (sys_rst),
        .wr_en   (in_push),
        .wr_data (host_in_data),
        .rd_en   (in_pop),
        .rd_data (cpu_din),
        .full    (in_full),
        .empty   (in_empty),
        .count   (in_count)
    );

    // ---------------------------------------------------------------------
    // Output path: CPU -> host
    // ---------------------------------------------------------------------
    logic out_full;
    logic out_empty;
    logic out_push;
    logic out_pop;
    logic out_drop;

    assign out_pop        = host_out_ready && !out_empty;
    // A drain in the same cycle frees a slot, so a write at full still lands.
    assign out_push       = cpu_dout_we && (!out_full || out_pop);
    assign out_drop       = cpu_dout_we && out_full && !out_pop;
    assign host_out_valid = !out_empty;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .srst    (sys_rst),
        .wr_en   (out_push),
        .wr_data (cpu_dout),
        .rd_en   (out_pop),
        .rd_data (host_out_data),
        .full    (out_full),
        .empty   (out_empty),
        .count   (out_count)
    );

    // ---------------------------------------------------------------------
    // Sticky error flags, cleared only by reset
    // ---------------------------------------------------------------------
    logic in_underflow_q, in_underflow_d;
    logic out_overflow_q, out_overflow_d;

    always_comb begin
        in_underflow_d = in_underflow_q;
        out_overflow_d = out_overflow_q;
        // A read against an empty FIFO is flagged even when a push lands in
        // the same cycle; that word was not yet visible to the CPU.
        if (cpu_din_rd && in_empty) begin
            in_underflow_d = 1'b1;
        end
        if (out_drop) begin
            out_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            in_underflow_q <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            in_underflow_q <= in_underflow_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign in_underflow = in_underflow_q;
    assign out_overflow = out_overflow_q;

endmodule : cpu_io_bridge

// File: tb/tb_cpu_io_bridge.sv
module tb_cpu_io_bridge;
    import cpu_io_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk;
    logic          sys_rst;
    logic [DW-1:0] host_in_data;
    logic          host_in_valid;
    logic          host_in_ready;
    logic [DW-1:0] cpu_din;
    logic          cpu_din_valid;
    logic          cpu_din_rd;
    logic [DW-1:0] cpu_dout;
    logic          cpu_dout_we;
    logic [DW-1:0] host_out_data;
    logic          host_out_valid;
    logic          host_out_ready;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;
    logic          in_underflow;
    logic          out_overflow;

    int checks = 0;
    int errors = 0;

    cpu_io_bridge #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .sys_rst        (sys_rst),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .cpu_din        (cpu_din),
        .cpu_din_valid  (cpu_din_valid),
        .cpu_din_rd     (cpu_din_rd),
        .cpu_dout       (cpu_dout),
        .cpu_dout_we    (cpu_dout_we),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .in_count       (in_count),
        .out_count      (out_count),
        .in_underflow   (in_underflow),
        .out_overflow   (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        word_t w;

        sys_rst        = 1'b1;
        host_in_data   = '0;
        host_in_valid  = 1'b0;
        cpu_din_rd     = 1'b0;
        cpu_dout       = '0;
        cpu_dout_we    = 1'b0;
        host_out_ready = 1'b0;

        // ---- 1: reset for two cycles with random inputs ----
        for (int i = 0; i < 2; i++) begin
            host_in_data   = 16'($urandom);
            host_in_valid  = 1'($urandom);
            cpu_din_rd     = 1'($urandom);
            cpu_dout       = 16'($urandom);
            cpu_dout_we    = 1'($urandom);
            host_out_ready = 1'($urandom);
            tick();
        end
        sys_rst        = 1'b0;
        host_in_valid  = 1'b0;
        cpu_din_rd     = 1'b0;
        cpu_dout_we    = 1'b0;
        host_out_ready = 1'b0;
        chk("rst_in_ready",  32'(host_in_ready),  32'd1);
        chk("rst_din_valid", 32'(cpu_din_valid),  32'd0);
        chk("rst_out_valid", 32'(host_out_valid), 32'd0);
        chk("rst_cpu_din",   32'(cpu_din),        32'd0);
        chk("rst_out_data",  32'(host_out_data),  32'd0);
        chk("rst_in_count",  32'(in_count),       32'd0);
        chk("rst_out_count", 32'(out_count),      32'd0);
        chk("rst_underflow", 32'(in_underflow),   32'd0);
        chk("rst_overflow",  32'(out_overflow),   32'd0);
        $display("T1 reset state checked");

        // ---- 2: push three words, read them back ----
        host_in_valid = 1'b1;
        host_in_data  = 16'h0001;
        tick();
        chk("t2_first_din",   32'(cpu_din),       32'h0001);
        chk("t2_first_valid", 32'(cpu_din_valid), 32'd1);
        host_in_data = 16'h0002;
        tick();
        host_in_data = 16'h0003;
        tick();
        host_in_valid = 1'b0;
        chk("t2_in_count3", 32'(in_count), 32'd3);
        cpu_din_rd = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("t2_read", 32'(cpu_din), 32'(i));
            tick();
        end
        cpu_din_rd = 1'b0;
        chk("t2_empty_valid", 32'(cpu_din_valid), 32'd0);
        chk("t2_empty_din",   32'(cpu_din),       32'd0);
        chk("t2_empty_count", 32'(in_count),      32'd0);
        $display("T2 three-word push/read checked");

        // ---- 3: fill input FIFO, 9th word held until a slot frees ----
        host_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_in_data = 16'h0010 + 16'(i);
            tick();
        end
        host_in_data = 16'h00FF;
        chk("t3_full_ready", 32'(host_in_ready), 32'd0);
        chk("t3_full_count", 32'(in_count),      32'd8);
        tick();
        chk("t3_held_count", 32'(in_count), 32'd8);
        cpu_din_rd = 1'b1;
        tick();
        cpu_din_rd = 1'b0;
        // Pop at full must not admit the held word in the same cycle.
        chk("t3_ready_back", 32'(host_in_ready), 32'd1);
        chk("t3_count7",     32'(in_count),      32'd7);
        tick();
        host_in_valid = 1'b0;
        chk("t3_count8_again", 32'(in_count), 32'd8);
        cpu_din_rd = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("t3_read", 32'(cpu_din), 32'h0010 + 32'(i));
            tick();
        end
        chk("t3_read_last", 32'(cpu_din), 32'h00FF);
        tick();
        cpu_din_rd = 1'b0;
        chk("t3_drained", 32'(cpu_din_valid), 32'd0);
        $display("T3 input full/backpressure checked");

        // ---- 4: output overflow drops 0xDEAD ----
        host_out_ready = 1'b0;
        cpu_dout_we    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_dout = 16'h00A0 + 16'(i);
            tick();
        end
        cpu_dout = 16'hDEAD;
        tick();
        cpu_dout_we = 1'b0;
        chk("t4_out_count", 32'(out_count),    32'd8);
        chk("t4_overflow",  32'(out_overflow), 32'd1);
        host_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain", 32'(host_out_data), 32'h00A0 + 32'(i));
            tick();
        end
        host_out_ready = 1'b0;
        chk("t4_no_dead_valid", 32'(host_out_valid), 32'd0);
        chk("t4_no_dead_data",  32'(host_out_data),  32'd0);
        $display("T4 output overflow checked");

        // ---- 5: write at full with same-cycle drain ----
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t5_ovf_cleared", 32'(out_overflow), 32'd0);
        cpu_dout_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_dout = 16'h00B0 + 16'(i);
            tick();
        end
        chk("t5_full_count", 32'(out_count), 32'd8);
        cpu_dout       = 16'h1234;
        host_out_ready = 1'b1;
        tick();
        cpu_dout_we    = 1'b0;
        host_out_ready = 1'b0;
        chk("t5_count_stays", 32'(out_count),     32'd8);
        chk("t5_no_overflow", 32'(out_overflow),  32'd0);
        chk("t5_head",        32'(host_out_data), 32'h00B1);
        host_out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("t5_drain", 32'(host_out_data), 32'h00B0 + 32'(i));
            tick();
        end
        chk("t5_last", 32'(host_out_data), 32'h1234);
        tick();
        host_out_ready = 1'b0;
        chk("t5_empty", 32'(host_out_valid), 32'd0);
        $display("T5 write-at-full with drain checked");

        // ---- 6: underflow, then reset mid-operation ----
        // Read against empty FIFO while a push lands: push survives, flag set.
        host_in_valid = 1'b1;
        host_in_data  = 16'h0055;
        cpu_din_rd    = 1'b1;
        tick();
        host_in_valid = 1'b0;
        cpu_din_rd    = 1'b0;
        chk("t6_uf_push_flag",  32'(in_underflow), 32'd1);
        chk("t6_uf_push_count", 32'(in_count),     32'd1);
        chk("t6_uf_push_data",  32'(cpu_din),      32'h0055);
        cpu_din_rd = 1'b1;
        tick();
        cpu_din_rd = 1'b1;
        tick();
        cpu_din_rd = 1'b0;
        chk("t6_uf_flag",  32'(in_underflow), 32'd1);
        chk("t6_uf_count", 32'(in_count),     32'd0);
        host_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = 16'h0060 + 16'(i);
            host_in_data = w;
            tick();
        end
        host_in_valid = 1'b0;
        chk("t6_loaded5", 32'(in_count), 32'd5);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t6_rst_count", 32'(in_count),      32'd0);
        chk("t6_rst_uf",    32'(in_underflow),  32'd0);
        chk("t6_rst_valid", 32'(cpu_din_valid), 32'd0);
        chk("t6_rst_din",   32'(cpu_din),       32'd0);
        tick();
        chk("t6_post_valid", 32'(cpu_din_valid), 32'd0);
        chk("t6_post_ready", 32'(host_in_ready), 32'd1);
        $display("T6 underflow and mid-operation reset checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cpu_io_bridge

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
Host-side I/O bridge for the 16-bit CPU's din/dout port. It sits between the CPU top level and an external host or testbench agent. Host words are buffered in an input FIFO and presented to the CPU on din. CPU output writes on dout are captured into an output FIFO and drained by the host over a valid/ready handshake.

Parameters:
DW, 16, data word width (matches CPU din/dout)
DEPTH, 8, entries per FIFO; power of 2, >= 2
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
host_in_data  in  DW  word from host destined for CPU din
host_in_valid  in  1  host_in_data valid
host_in_ready  out  1  input FIFO can accept a word
cpu_din  out  DW  head of input FIFO (first-word fall-through); 0 when empty
cpu_din_valid  out  1  input FIFO non-empty
cpu_din_rd  in  1  CPU consumed cpu_din; pop
cpu_dout  in  DW  CPU output word
cpu_dout_we  in  1  CPU write strobe for cpu_dout
host_out_data  out  DW  head of output FIFO; 0 when empty
host_out_valid  out  1  output FIFO non-empty
host_out_ready  in  1  host accepts host_out_data
in_count  out  CW  input FIFO occupancy
out_count  out  CW  output FIFO occupancy
in_underflow  out  1  sticky: cpu_din_rd seen while input FIFO empty
out_overflow  out  1  sticky: CPU write dropped because output FIFO full

Behaviour:
- Reset:
  - sys_rst sampled at posedge clears both FIFO pointers and counts to 0.
  - Clears in_underflow and out_overflow.
  - Outputs from the cycle after the reset edge: host_in_ready=1, cpu_din_valid=0, host_out_valid=0, cpu_din=0, host_out_data=0, counts=0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all buffered words; no partial transfer survives.
- Input path:
  - Push when host_in_valid && host_in_ready.
  - host_in_ready = !in_full, derived from registered state only; no combinational dependence on cpu_din_rd.
  - When full, a same-cycle pop does not enable a push; ready rises on the next cycle.
  - Latency: word pushed at edge N appears on cpu_din/cpu_din_valid after edge N (visible in cycle N+1).
  - Pop when cpu_din_rd && cpu_din_valid.
  - cpu_din_rd while empty: ignored and in_underflow set. This includes a same-cycle push into an empty FIFO; the push still succeeds.
- Output path:
  - Write is accepted when cpu_dout_we && (!out_full || (host_out_valid && host_out_ready)). A same-cycle drain frees a slot.
  - Write while full with no drain: word dropped, out_overflow set.
  - Pop when host_out_valid && host_out_ready.
  - Host sees a word the cycle after the CPU writes it.
- FIFO counters:
  - Pointers are AW=CW-1 bits, wrap mod DEPTH naturally.
  - Count increments on push only, decrements on pop only, unchanged on simultaneous push and pop.
  - full = (count==DEPTH), empty = (count==0).
  - Order strictly preserved in both directions.
- Sticky flags clear only on sys_rst.
- Data outputs are masked to 0 when the corresponding valid is 0.

Decomposition:
- Package cpu_io_pkg holds:
  - DW_DEFAULT=16
  - typedef word_t (logic [DW-1:0])
  - DEPTH_DEFAULT=8
- Sub-module sync_fifo (parameters DW, DEPTH), instantiated twice.
  - Signals: wr_en, wr_data, rd_en, rd_data (FWFT), full, empty, count.
  - Pointer/count logic, storage, and output masking live inside sync_fifo.
- The bridge top adds handshake gating and the sticky flags.

Test Plan:
1. Assert sys_rst 2 cycles with random inputs -> cycle after release: host_in_ready=1, both valids 0, cpu_din=0, host_out_data=0, counts 0, flags 0.
2. Host pushes 0x0001, 0x0002, 0x0003 back-to-back -> cpu_din=0x0001 one cycle after first push, in_count=3. Three cpu_din_rd pulses -> values 0x0001, 0x0002, 0x0003 in order, then cpu_din_valid=0, cpu_din=0.
3. Push 8 words with no reads -> host_in_ready=0, in_count=8, 9th word 0x00FF held by host. One cpu_din_rd -> host_in_ready=1 next cycle, 0x00FF accepted, later read out last.
4. host_out_ready=0; CPU writes 0x00A0..0x00A7 then 0xDEAD -> out_count=8, out_overflow=1. Drain -> exactly 0x00A0..0x00A7, no 0xDEAD.
5. Output FIFO full; same cycle host_out_ready=1 and cpu_dout_we with 0x1234 -> write accepted, out_count stays 8, overflow stays 0, 0x1234 emerges last.
6. cpu_din_rd with input empty -> in_underflow=1, in_count=0. Load 5 words, assert sys_rst one cycle -> in_count=0, flags cleared, cpu_din_valid=0 next cycle.
